// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack handshake,
// lane-aligns load data and drives the registered MEM/WB bus.
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [31:0] ALUData,
  input  logic [31:0] RtData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic [2:0]  Memfunc,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_ALUData,
  output logic [31:0] wb_RtData,
  output logic [31:0] wb_MemData,
  output logic [2:0]  wb_Memfunc,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_WriteReg,
  output logic        mem_err
);

  localparam logic [2:0] F_BS = 3'd0, F_BU = 3'd1, F_HS = 3'd2, F_HU = 3'd3;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        kill_p1;
  logic        load_p1, memtoreg_p1, regwrite_p1;
  logic [31:0] alu_p1, rt_p1;
  logic [2:0]  func_p1;
  logic [4:0]  wreg_p1;
  logic        accept, memop, mis, timeout;

  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    case (f)
      F_BS, F_BU: misaligned = 1'b0;
      F_HS, F_HU: misaligned = a[0];
      default:    misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] a);
    case (f)
      F_BS, F_BU: store_be = 4'b0001 << a;
      F_HS, F_HU: store_be = a[1] ? 4'b1100 : 4'b0011;
      default:    store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f, input logic [31:0] rt);
    case (f)
      F_BS, F_BU: store_data = {4{rt[7:0]}};
      F_HS, F_HU: store_data = {2{rt[15:0]}};
      default:    store_data = rt;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 so WB extends from [7:0]/[15:0].
  function automatic logic [31:0] align_load(input logic [2:0] f, input logic [1:0] a,
                                             input logic [31:0] rd);
    case (f)
      F_BS, F_BU: align_load = (rd >> {a, 3'b000}) & 32'h0000_00FF;
      F_HS, F_HU: align_load = (rd >> {a[1], 4'b0000}) & 32'h0000_FFFF;
      default:    align_load = rd;
    endcase
  endfunction

  assign accept   = (state == IDLE) && ex_valid && !flush;
  assign memop    = MemRead || MemWrite;
  assign mis      = misaligned(Memfunc, ALUData[1:0]);
  assign timeout  = (state == REQ) && !dmem_ack && (wait_cnt == WAIT_LAST);
  assign dmem_req = (state == REQ);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A timed-out access retires like a completed one, so EX is released too.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    if (nrst) begin
      case (state)
        IDLE: if (accept && memop && !mis) begin
          state_nxt = REQ;
          stall     = 1'b1;
        end
        REQ: begin
          stall = !dmem_ack && !timeout;
          if (dmem_ack || timeout) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt    <= '0;
      kill_p1     <= 1'b0;
      load_p1     <= 1'b0;
      memtoreg_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      alu_p1      <= '0;
      rt_p1       <= '0;
      func_p1     <= '0;
      wreg_p1     <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_ALUData  <= '0;
      wb_RtData   <= '0;
      wb_MemData  <= '0;
      wb_Memfunc  <= '0;
      wb_RegWrite <= 1'b0;
      wb_WriteReg <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (!memop || mis) begin
            // p0 -> WB directly: ALU op, or misaligned access retired as an error
            wb_valid    <= 1'b1;
            wb_MemtoReg <= MemtoReg;
            wb_ALUData  <= ALUData;
            wb_RtData   <= RtData;
            wb_MemData  <= '0;
            wb_Memfunc  <= Memfunc;
            wb_RegWrite <= RegWrite && !memop;
            wb_WriteReg <= WriteReg;
            mem_err     <= memop;
          end else begin
            // p0 -> p1: request held stable for the whole REQ phase
            load_p1     <= MemRead;
            memtoreg_p1 <= MemtoReg;
            regwrite_p1 <= RegWrite;
            alu_p1      <= ALUData;
            rt_p1       <= RtData;
            func_p1     <= Memfunc;
            wreg_p1     <= WriteReg;
            wait_cnt    <= '0;
            kill_p1     <= 1'b0;
            dmem_we     <= MemWrite;
            dmem_addr   <= {ALUData[31:2], 2'b00};
            dmem_be     <= MemWrite ? store_be(Memfunc, ALUData[1:0]) : 4'b1111;
            dmem_wdata  <= store_data(Memfunc, RtData);
          end
        end
      end else if (dmem_ack || timeout) begin
        // p1 -> WB; a flush seen at any point in REQ discards the result
        mem_err <= timeout;
        if (!(kill_p1 || flush)) begin
          wb_valid    <= 1'b1;
          wb_MemtoReg <= memtoreg_p1;
          wb_ALUData  <= alu_p1;
          wb_RtData   <= rt_p1;
          wb_MemData  <= (load_p1 && dmem_ack) ? align_load(func_p1, alu_p1[1:0], dmem_rdata) : '0;
          wb_Memfunc  <= func_p1;
          wb_RegWrite <= regwrite_p1 && dmem_ack;
          wb_WriteReg <= wreg_p1;
        end
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
        if (flush) kill_p1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// loads/stores/ALU ops checked against a behavioural model of the stage.
module tb_mem_access_stage;

  localparam int MW = 15;
  localparam logic [2:0] F_BS = 3'd0, F_BU = 3'd1, F_HS = 3'd2, F_HU = 3'd3,
                         F_WD = 3'd4, F_WL = 3'd5, F_WR = 3'd6, F_WC = 3'd7;

  logic        clk, nrst, ex_valid, flush;
  logic [31:0] ALUData, RtData;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [2:0]  Memfunc;
  logic [4:0]  WriteReg;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_MemtoReg, wb_RegWrite, mem_err;
  logic [31:0] wb_ALUData, wb_RtData, wb_MemData;
  logic [2:0]  wb_Memfunc;
  logic [4:0]  wb_WriteReg;

  int checks = 0;
  int errors = 0;

  // Observations collected by exec_op
  int          obs_stall, obs_reqc;
  logic        obs_stable, obs_we, obs_wbv, obs_err, obs_rw;
  logic [31:0] obs_addr, obs_wdata, obs_md, obs_alu;
  logic [3:0]  obs_be;
  logic [4:0]  obs_wreg;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .flush(flush),
    .ALUData(ALUData), .RtData(RtData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .Memfunc(Memfunc), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg),
    .wb_ALUData(wb_ALUData), .wb_RtData(wb_RtData), .wb_MemData(wb_MemData),
    .wb_Memfunc(wb_Memfunc), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access size in bytes and derived lane arithmetic
  function automatic int fsize(input logic [2:0] f);
    if (f == F_BS || f == F_BU) return 1;
    if (f == F_HS || f == F_HU) return 2;
    return 4;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f, input logic [31:0] a);
    return (a % fsize(f)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a, input logic st);
    int mask;
    if (!st) return 4'hF;
    mask = ((2 ** fsize(f)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] rt);
    if (fsize(f) == 1) return (rt % 256) * 32'h0101_0101;
    if (fsize(f) == 2) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    v = longint'(rd) >> (8 * (a % 4));
    return 32'(v % (longint'(1) << (8 * fsize(f))));
  endfunction

  task automatic exec_op(input logic rd, input logic wr, input logic [2:0] f,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] rdata,
                         input logic rw, input logic [4:0] wreg,
                         input int ack_at, input int flush_at, input logic flush0);
    int   r;
    logic done;
    @(negedge clk);
    ex_valid = 1'b1; MemRead = rd; MemWrite = wr; MemtoReg = rd; Memfunc = f;
    ALUData = alu; RtData = rt; RegWrite = rw; WriteReg = wreg;
    flush = flush0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1 obs_stall = stall ? 1 : 0;
    r = 0; done = 1'b0; obs_stable = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!dmem_req) done = 1'b1;
      else begin
        flush = (r == flush_at); dmem_ack = (r == ack_at); dmem_rdata = rdata;
        if (r == 0) begin
          obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {obs_addr, obs_be, obs_wdata, obs_we})
          obs_stable = 1'b0;
        #1 if (stall) obs_stall++;
        r++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_bound dmem_req still high after %0d cycles, required low", r);
    end
    obs_reqc = r; obs_wbv = wb_valid; obs_err = mem_err; obs_rw = wb_RegWrite;
    obs_md = wb_MemData; obs_alu = wb_ALUData; obs_wreg = wb_WriteReg;
    ex_valid = 1'b0; flush = 1'b0; dmem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; ex_valid = 1'b0; flush = 1'b0; ALUData = '0; RtData = '0;
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; Memfunc = '0; RegWrite = 1'b0;
    WriteReg = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_RegWrite, mem_err} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 0", {stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_RegWrite, mem_err});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_ALUData, wb_MemData} !== 128'b0) begin
      errors++; $display("FAIL reset_data got %h required 0", {dmem_addr, dmem_wdata, wb_ALUData, wb_MemData});
    end
    nrst = 1'b1;
  endtask

  task automatic test_byte_load();
    logic [31:0] wbout;
    exec_op(1'b1, 1'b0, F_BS, 32'h1003, 32'h0, 32'h80AABBCC, 1'b1, 5'd7, 3, -1, 1'b0);
    wbout = {{24{obs_md[7]}}, obs_md[7:0]};
    checks++; if (obs_stall !== 4) begin errors++; $display("FAIL bs_stall got %0d required 4", obs_stall); end
    checks++; if (obs_md !== 32'h80) begin errors++; $display("FAIL bs_memdata got %h required 00000080", obs_md); end
    checks++; if (wbout !== 32'hFFFFFF80) begin errors++; $display("FAIL bs_wbout got %h required ffffff80", wbout); end
    checks++; if ({obs_wbv, obs_rw, obs_err, obs_addr} !== {3'b110, 32'h1000}) begin
      errors++; $display("FAIL bs_ctrl got %b/%h required 110/00001000", {obs_wbv, obs_rw, obs_err}, obs_addr);
    end
  endtask

  task automatic test_half_store();
    exec_op(1'b0, 1'b1, F_HU, 32'h2002, 32'h1234ABCD, 32'h0, 1'b0, 5'd0, 2, -1, 1'b0);
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL hu_be got %b required 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL hu_wdata got %h required abcdabcd", obs_wdata); end
    checks++; if (obs_addr !== 32'h2000) begin errors++; $display("FAIL hu_addr got %h required 00002000", obs_addr); end
    checks++; if ({obs_we, obs_stable, obs_wbv} !== 3'b111 || obs_reqc !== 3) begin
      errors++; $display("FAIL hu_hold got we/stable/wbv %b reqc %0d required 111 reqc 3", {obs_we, obs_stable, obs_wbv}, obs_reqc);
    end
  endtask

  task automatic test_misaligned();
    exec_op(1'b1, 1'b0, F_WD, 32'h3001, 32'h0, 32'h0, 1'b1, 5'd3, 0, -1, 1'b0);
    checks++; if (obs_reqc !== 0) begin errors++; $display("FAIL mis_req got %0d req cycles required 0", obs_reqc); end
    checks++; if ({obs_err, obs_wbv, obs_rw} !== 3'b110) begin
      errors++; $display("FAIL mis_flags got err/wbv/rw %b required 110", {obs_err, obs_wbv, obs_rw});
    end
    @(negedge clk);
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mis_pulse got mem_err %b required 0", mem_err); end
  endtask

  task automatic test_timeout();
    exec_op(1'b1, 1'b0, F_WD, 32'h5000, 32'h0, 32'h0, 1'b1, 5'd9, -1, -1, 1'b0);
    checks++; if (obs_reqc !== MW) begin errors++; $display("FAIL to_reqc got %0d required %0d", obs_reqc, MW); end
    checks++; if ({obs_err, obs_wbv, obs_rw} !== 3'b110) begin
      errors++; $display("FAIL to_flags got err/wbv/rw %b required 110", {obs_err, obs_wbv, obs_rw});
    end
    #1;
    checks++; if ({stall, dmem_req} !== 2'b00) begin errors++; $display("FAIL to_release got stall/req %b required 00", {stall, dmem_req}); end
  endtask

  task automatic test_flush();
    exec_op(1'b0, 1'b0, F_WD, 32'h77, 32'h0, 32'h0, 1'b1, 5'd4, 0, -1, 1'b1);
    checks++; if ({obs_wbv, obs_stall[0]} !== 2'b00) begin errors++; $display("FAIL flush_idle got wbv %b stall %0d required 0 0", obs_wbv, obs_stall); end
    exec_op(1'b1, 1'b0, F_WD, 32'h6000, 32'h0, 32'h11223344, 1'b1, 5'd4, 3, 1, 1'b0);
    checks++; if ({obs_wbv, obs_reqc[3:0]} !== {1'b0, 4'd4}) begin
      errors++; $display("FAIL flush_req got wbv %b reqc %0d required 0 4", obs_wbv, obs_reqc);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; Memfunc = F_WD;
    ALUData = 32'hCAFE0001; RegWrite = 1'b1; WriteReg = 5'd5; flush = 1'b0;
    #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_alu_stall got %b required 0", stall); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_RegWrite, wb_ALUData} !== {2'b11, 32'hCAFE0001}) begin
      errors++; $display("FAIL b2b_alu got v/rw %b data %h required 11 cafe0001", {wb_valid, wb_RegWrite}, wb_ALUData);
    end
    MemRead = 1'b1; MemtoReg = 1'b1; ALUData = 32'h8000; WriteReg = 5'd6;
    #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_ld_stall got %b required 1", stall); end
    @(negedge clk);
    checks++; if ({dmem_req, wb_valid} !== 2'b10) begin errors++; $display("FAIL b2b_req got req/wbv %b required 10", {dmem_req, wb_valid}); end
    dmem_ack = 1'b1; flush = 1'b1; dmem_rdata = 32'h5555AAAA;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0; dmem_ack = 1'b0; flush = 1'b0;
    checks++; if ({dmem_req, wb_valid} !== 2'b00) begin errors++; $display("FAIL b2b_discard got req/wbv %b required 00", {dmem_req, wb_valid}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int k, ack_at, flush_at;
      logic rd, wr, rw, mis, goes;
      logic [2:0] f;
      logic [31:0] alu, rt, rdata;
      logic [4:0] wreg;
      k = int'($urandom_range(0, 2));
      rd = (k == 1); wr = (k == 2);
      f = 3'($urandom_range(0, 7));
      alu = $urandom; if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      rt = $urandom; rdata = $urandom; rw = 1'($urandom_range(0, 1)); wreg = 5'($urandom_range(0, 31));
      ack_at = int'($urandom_range(0, 4));
      flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ack_at)) : -1;
      exec_op(rd, wr, f, alu, rt, rdata, rw, wreg, ack_at, flush_at, 1'b0);
      mis  = (rd || wr) && ref_mis(f, alu);
      goes = (rd || wr) && !mis;
      checks++; if (obs_reqc !== (goes ? ack_at + 1 : 0) || obs_stall !== (goes ? ack_at + 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_timing got reqc %0d stall %0d required %0d", i, obs_reqc, obs_stall, goes ? ack_at + 1 : 0);
      end
      checks++; if ({obs_wbv, obs_err} !== {!(goes && flush_at >= 0), mis}) begin
        errors++; $display("FAIL rnd%0d_flags got wbv/err %b required %b", i, {obs_wbv, obs_err}, {!(goes && flush_at >= 0), mis});
      end
      if (goes) begin
        checks++;
        if ({obs_addr, obs_be, obs_we, obs_stable} !== {alu - (alu % 4), ref_be(f, alu, wr), wr, 1'b1}) begin
          errors++; $display("FAIL rnd%0d_req got %h/%b/%b/%b required %h/%b/%b/1", i, obs_addr, obs_be, obs_we, obs_stable, alu - (alu % 4), ref_be(f, alu, wr), wr);
        end
        if (wr) begin
          checks++; if (obs_wdata !== ref_wdata(f, rt)) begin errors++; $display("FAIL rnd%0d_wdata got %h required %h", i, obs_wdata, ref_wdata(f, rt)); end
        end
      end
      if (obs_wbv) begin
        checks++; if ({obs_rw, obs_alu, obs_wreg} !== {rw && !mis, alu, wreg}) begin
          errors++; $display("FAIL rnd%0d_wb got %b/%h/%0d required %b/%h/%0d", i, obs_rw, obs_alu, obs_wreg, rw && !mis, alu, wreg);
        end
        if (rd && goes) begin
          checks++; if (obs_md !== ref_md(f, alu, rdata)) begin errors++; $display("FAIL rnd%0d_md got %h required %h", i, obs_md, ref_md(f, alu, rdata)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Memfunc = F_WD; ALUData = 32'h4000; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got req %b required 1", dmem_req); end
    #2 nrst = 1'b0;
    #1 checks++; if ({dmem_req, wb_valid, stall} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got req/wbv/stall %b required 000", {dmem_req, wb_valid, stall});
    end
    ex_valid = 1'b0; MemRead = 1'b0;
    @(negedge clk) nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
